// File: rtl/ksa_pipe_adder_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
package ksa_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/ksa_pipe_adder_if.sv
// Operand/result stream bundle between the issue logic and the adder.
// Handshake: a beat moves on a rising edge where valid and ready are both 1; a source holding
// valid=1 keeps its payload stable until that edge, and ready may be asserted with valid=0.
interface ksa_pipe_adder_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             cin_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum_o;
    logic             cout_o;
    logic             ovf_o;

    modport master (
        output in_valid, a_i, b_i, cin_i, out_ready,
        input  in_ready, out_valid, sum_o, cout_o, ovf_o
    );

    modport slave (
        input  in_valid, a_i, b_i, cin_i, out_ready,
        output in_ready, out_valid, sum_o, cout_o, ovf_o
    );
endinterface

// File: rtl/ksa_pipe_adder_cells.sv
// Kogge-Stone black cell: merges group (g,p) of bit i with the group ending d bits lower.
module cells (
    input  logic p_i,
    input  logic p_j,
    input  logic g_i,
    input  logic g_j,
    output logic p_o,
    output logic g_o
);
    assign g_o = g_i | (p_i & g_j);
    assign p_o = p_i & p_j;
endmodule

// File: rtl/ksa_pipe_adder.sv
// Parametrised Kogge-Stone adder with an optional register after each prefix level and a
// single global stall enable so the whole pipe advances or holds as one.
module ksa_pipe_adder
    import ksa_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PIPE  = 1
) (
    input logic            clk,
    input logic            rst,
    ksa_pipe_adder_if.slave bus
);
    localparam int LOG2W = $clog2(WIDTH);

    if (!is_pow2(WIDTH) || WIDTH < 4 || WIDTH > 128) begin : g_bad_width
        $error("ksa_pipe_adder: WIDTH must be a power of 2 in 4..128");
    end

    logic en;
    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;

    pg_t  [WIDTH-1:0] pre_pg;
    pg_t  [WIDTH-1:0] s0_pg;
    logic [WIDTH-1:0] s0_p;
    logic             s0_cin;
    logic             s0_vld;

    // Carry-in is folded into bit 0's generate so the prefix tree needs no extra column.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pre_pg[i].p = bus.a_i[i] ^ bus.b_i[i];
            pre_pg[i].g = bus.a_i[i] & bus.b_i[i];
        end
        pre_pg[0].g = (bus.a_i[0] & bus.b_i[0]) | ((bus.a_i[0] ^ bus.b_i[0]) & bus.cin_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_vld <= 1'b0;
            s0_pg  <= '0;
            s0_p   <= '0;
            s0_cin <= 1'b0;
        end else if (en) begin
            s0_vld <= bus.in_valid;
            s0_pg  <= pre_pg;
            s0_p   <= bus.a_i ^ bus.b_i;
            s0_cin <= bus.cin_i;
        end
    end

    for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
        localparam int D = 1 << k;
        pg_t  [WIDTH-1:0] in_pg;
        pg_t  [WIDTH-1:0] nxt;
        pg_t  [WIDTH-1:0] out_pg;
        logic [WIDTH-1:0] in_p;
        logic [WIDTH-1:0] out_p;
        logic [WIDTH-1:0] ng;
        logic [WIDTH-1:0] np;
        logic             in_cin;
        logic             out_cin;
        logic             in_vld;
        logic             out_vld;

        if (k == 0) begin : g_src0
            assign in_pg  = s0_pg;
            assign in_p   = s0_p;
            assign in_cin = s0_cin;
            assign in_vld = s0_vld;
        end else begin : g_srck
            assign in_pg  = g_lvl[k-1].out_pg;
            assign in_p   = g_lvl[k-1].out_p;
            assign in_cin = g_lvl[k-1].out_cin;
            assign in_vld = g_lvl[k-1].out_vld;
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= D) begin : g_cell
                cells u_cell (
                    .p_i(in_pg[i].p),
                    .p_j(in_pg[i-D].p),
                    .g_i(in_pg[i].g),
                    .g_j(in_pg[i-D].g),
                    .p_o(np[i]),
                    .g_o(ng[i])
                );
            end else begin : g_pass
                assign np[i] = in_pg[i].p;
                assign ng[i] = in_pg[i].g;
            end
        end

        always_comb begin
            for (int i = 0; i < WIDTH; i++) begin
                nxt[i].g = ng[i];
                nxt[i].p = np[i];
            end
        end

        if (PIPE != 0) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_vld <= 1'b0;
                    out_pg  <= '0;
                    out_p   <= '0;
                    out_cin <= 1'b0;
                end else if (en) begin
                    out_vld <= in_vld;
                    out_pg  <= nxt;
                    out_p   <= in_p;
                    out_cin <= in_cin;
                end
            end
        end else begin : g_wire
            assign out_vld = in_vld;
            assign out_pg  = nxt;
            assign out_p   = in_p;
            assign out_cin = in_cin;
        end
    end

    pg_t  [WIDTH-1:0] fin_pg;
    logic [WIDTH-1:0] fin_p;
    logic [WIDTH-1:0] fin_g;
    logic [WIDTH-1:0] carry;
    logic             fin_cin;
    logic             fin_vld;

    assign fin_pg  = g_lvl[LOG2W-1].out_pg;
    assign fin_p   = g_lvl[LOG2W-1].out_p;
    assign fin_cin = g_lvl[LOG2W-1].out_cin;
    assign fin_vld = g_lvl[LOG2W-1].out_vld;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            fin_g[i] = fin_pg[i].g;
        end
    end

    // Prefix G[i-1] is the carry into bit i; G[WIDTH-2] is therefore c[WIDTH-1].
    assign carry = {fin_g[WIDTH-2:0], fin_cin};

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.sum_o     <= '0;
            bus.cout_o    <= 1'b0;
            bus.ovf_o     <= 1'b0;
        end else if (en) begin
            bus.out_valid <= fin_vld;
            bus.sum_o     <= fin_p ^ carry;
            bus.cout_o    <= fin_g[WIDTH-1];
            bus.ovf_o     <= fin_g[WIDTH-1] ^ fin_g[WIDTH-2];
        end
    end
endmodule
